// File: rtl/weapon_bank.sv
// Multi-channel saturating ammo controller with a shared cooldown/reload FSM.
// Each channel keeps its own ammo count and programmable maximum.
module weapon_bank #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned W          = 9,
    parameter int unsigned MAX_DEF    = 500,
    parameter int unsigned COOLDOWN   = 2,
    parameter int unsigned RELOAD_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       mode_selector,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic             fire,
    input  logic             reload,
    input  logic [W-1:0]     reload_amt,
    input  logic             load_max,
    input  logic [W-1:0]     max_in,
    output logic [W-1:0]     ammo_out,
    output logic             empty,
    output logic             fired,
    output logic [1:0]       err,
    output logic             busy
);

    localparam logic [3:0]  MODE_ATTACK = 4'b0010;
    localparam logic [1:0]  ERR_NONE    = 2'b00;
    localparam logic [1:0]  ERR_DRY     = 2'b01;
    localparam logic [1:0]  ERR_MODE    = 2'b10;
    localparam logic [1:0]  ERR_RELOAD  = 2'b11;
    localparam int unsigned CNT_MAX     = (COOLDOWN > RELOAD_CYC) ? COOLDOWN : RELOAD_CYC;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COOLDOWN,
        S_RELOAD
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]   rl_ch, rl_ch_nxt;
    logic               fired_nxt;
    logic [1:0]         err_nxt;
    logic [W-1:0]       ammo     [N_CH];
    logic [W-1:0]       ammo_nxt [N_CH];
    logic [W-1:0]       max_r    [N_CH];
    logic [W-1:0]       max_nxt  [N_CH];
    logic [W:0]         rl_sum;
    logic [W-1:0]       rl_sat;

    assign ammo_out = ammo[ch_sel];
    assign empty    = (ammo_out == '0);
    assign busy     = (state != S_IDLE);

    // Reload sum is one bit wider than the ammo so it saturates instead of wrapping
    assign rl_sum = {1'b0, ammo[rl_ch]} + {1'b0, reload_amt};
    assign rl_sat = (rl_sum > {1'b0, max_r[rl_ch]}) ? max_r[rl_ch] : rl_sum[W-1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rl_ch_nxt = rl_ch;
        fired_nxt = 1'b0;
        err_nxt   = ERR_NONE;
        ammo_nxt  = ammo;
        max_nxt   = max_r;

        case (state)
            S_IDLE: begin
                if (!load_max) begin
                    if (reload) begin
                        state_nxt = S_RELOAD;
                        cnt_nxt   = CNT_W'(RELOAD_CYC);
                        rl_ch_nxt = ch_sel;
                    end else if (fire) begin
                        if (mode_selector != MODE_ATTACK) begin
                            err_nxt = ERR_MODE;
                        end else if (ammo[ch_sel] == '0) begin
                            err_nxt = ERR_DRY;
                        end else begin
                            ammo_nxt[ch_sel] = ammo[ch_sel] - W'(1);
                            fired_nxt        = 1'b1;
                            if (COOLDOWN > 0) begin
                                state_nxt = S_COOLDOWN;
                                cnt_nxt   = CNT_W'(COOLDOWN);
                            end
                        end
                    end
                end
            end
            S_COOLDOWN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RELOAD: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (fire && !load_max) begin
                    err_nxt = ERR_RELOAD;
                end
                if (cnt == CNT_W'(1)) begin
                    state_nxt       = S_IDLE;
                    ammo_nxt[rl_ch] = rl_sat;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Applied last so a new maximum also clamps a reload landing on the same edge
        if (load_max) begin
            max_nxt[ch_sel] = max_in;
            if (ammo_nxt[ch_sel] > max_in) begin
                ammo_nxt[ch_sel] = max_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            rl_ch <= '0;
            fired <= 1'b0;
            err   <= ERR_NONE;
            for (int unsigned i = 0; i < N_CH; i++) begin
                ammo[i]  <= '0;
                max_r[i] <= W'(MAX_DEF);
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rl_ch <= rl_ch_nxt;
            fired <= fired_nxt;
            err   <= err_nxt;
            for (int unsigned i = 0; i < N_CH; i++) begin
                ammo[i]  <= ammo_nxt[i];
                max_r[i] <= max_nxt[i];
            end
        end
    end

endmodule

// File: doc/weapon_bank.md
# weapon_bank

Multi-channel weapon ammunition controller, the parametrised successor to the single-channel saturating ammo counter. It holds one saturating ammo register and one programmable maximum per weapon channel. A shared state machine enforces a fire-rate cooldown and a timed reload sequence, and flags dry-fire and mode violations. It sits under the command module and is gated by the same one-hot mode selector, where 4'b0010 means attack mode.

## Interface
Parameters:
- N_CH, default 4: number of weapon channels (2..16).
- SEL_W, default 2: channel-select width; must equal ceil(log2(N_CH)).
- W, default 9: ammo and maximum width in bits.
- MAX_DEF, default 500: reset value of every channel maximum; must be < 2^W.
- COOLDOWN, default 2: number of cycles spent in COOLDOWN after an accepted shot. 0 disables cooldown.
- RELOAD_CYC, default 8: number of cycles spent in RELOAD; must be ≥ 1.

Ports (clock and reset first):
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- mode_selector, input, 4: one-hot mode. Firing is legal only when it equals 4'b0010.
- ch_sel, input, SEL_W: selects the channel for fire, reload, load_max and ammo_out.
- fire, input, 1: fire request, level sampled every edge.
- reload, input, 1: reload request.
- reload_amt, input, W: number of rounds added by a reload.
- load_max, input, 1: write max_in into max[ch_sel].
- max_in, input, W: new maximum value.
- ammo_out, output, W: current value of ammo[ch_sel], read combinationally from the registers.
- empty, output, 1: high when ammo_out == 0.
- fired, output, 1: one-cycle pulse marking an accepted shot.
- err, output, 2: one-cycle error code. 00 = none, 01 = dry fire, 10 = mode block, 11 = fire while reloading.
- busy, output, 1: high when state != IDLE.

## Operation
- State machine states: IDLE, COOLDOWN, RELOAD. A shared down-counter times COOLDOWN and RELOAD.
- Reset values: all ammo[i] = 0, all max[i] = MAX_DEF, state = IDLE, fired = 0, err = 00. After reset, ammo_out = 0, empty = 1, busy = 0.
- Request priority within one cycle, highest first: rst, load_max, reload, fire.
- load_max is accepted in any state:
  - max[ch_sel] takes max_in.
  - On the same edge, ammo[ch_sel] is clamped to min(ammo[ch_sel], max_in).
  - Other requests in that cycle are dropped, with no error.
- reload in IDLE:
  - The channel is latched (rl_ch) and the FSM enters RELOAD with counter = RELOAD_CYC.
  - On the edge that leaves RELOAD, ammo[rl_ch] takes min(ammo[rl_ch] + reload_amt, max[rl_ch]). The sum is computed at W+1 bits, so it never wraps.
  - reload_amt is sampled on that exit edge.
  - reload in COOLDOWN or RELOAD is ignored.
- fire in IDLE, with load_max and reload both low:
  - mode_selector != 4'b0010: err = 10. No ammo change, no state change.
  - mode is attack and ammo[ch_sel] == 0: err = 01. No state change.
  - Otherwise: ammo[ch_sel] decrements by 1 and fired = 1. If COOLDOWN > 0, the FSM enters COOLDOWN with counter = COOLDOWN; otherwise it stays in IDLE.
- fire in COOLDOWN: silently ignored. This is the rate limit.
- fire in RELOAD: err = 11. Ammo is unchanged.
- Ammo never goes below 0 or above the channel's max. Channels are fully independent except for the shared FSM.
- Changing ch_sel during RELOAD does not affect rl_ch.

## Timing
- fired and err are registered. They assert for exactly the one cycle following the sampling edge, then clear to 0/00 on the next edge unless a new event occurs.
- ammo_out reflects a new ammo value in the cycle after the update edge, with zero additional latency.
- After an accepted shot at edge k, the next shot can be accepted no earlier than edge k+COOLDOWN+1. With COOLDOWN = 0, one shot per cycle is possible.
- A reload request at edge k produces the ammo update at edge k+RELOAD_CYC. The FSM is back in IDLE, with busy = 0, from that edge on.
- rst asserted in COOLDOWN or RELOAD aborts the operation: no pending ammo write, and everything returns to reset values on that edge.

## Test plan
- Reset, then load_max ch0 with max_in = 10, then reload ch0 with reload_amt = 500 -> busy for 8 cycles, then ammo_out = 10 (saturation).
- Attack mode with fire held continuously on ch0 holding 5 rounds, COOLDOWN = 2 -> fired pulses every 3 cycles; ammo goes 4, 3, 2, 1, 0; the next accepted-slot cycle gives err = 01; empty = 1.
- mode_selector = 4'b0100, fire on ch1 holding 3 rounds -> err = 10, ammo stays 3, fired = 0.
- Reload ch2 (holding 0, reload_amt = 7), switch ch_sel to 3 and pulse fire mid-reload -> err = 11; after 8 cycles ammo[2] = 7 and ammo[3] is unchanged.
- reload and fire in the same IDLE cycle -> reload wins, no fired pulse, no err. Separately, load_max = 2 on a channel holding 9 -> ammo clamps to 2 on the same edge.
- rst asserted 3 cycles into a reload -> busy = 0 and all ammo = 0 on the next edge; the reload write never occurs.
